// File: rtl/process_engine_pkg.sv
// rtl/process_engine_pkg.sv - shared opcodes, return codes and instruction sizing
package process_engine_pkg;

  typedef enum logic [3:0] {
    OP_SET  = 4'd0,
    OP_GE   = 4'd1,
    OP_GT   = 4'd2,
    OP_LE   = 4'd3,
    OP_LT   = 4'd4,
    OP_NE   = 4'd5,
    OP_EQ   = 4'd6,
    OP_ADD  = 4'd7,
    OP_JMP  = 4'd8,
    OP_JZ   = 4'd9,
    OP_HALT = 4'd10
  } opcode_e;

  localparam logic [7:0] RC_HALT    = 8'd0;
  localparam logic [7:0] RC_END     = 8'd1;
  localparam logic [7:0] RC_ILLEGAL = 8'd2;

  // [op:4][dst:RA][srcA:RA][srcB:RA][imm:WIDTH]
  function automatic int instr_w(input int width, input int nregs);
    return 4 + 3 * $clog2(nregs) + width;
  endfunction

endpackage

// File: rtl/process_alu.sv
// rtl/process_alu.sv - combinational datapath for compare, set, add and branch decode
module process_alu
  import process_engine_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] result,
  output logic             writes_reg,
  output logic             is_branch,
  output logic             branch_taken
);

  always_comb begin
    result       = '0;
    writes_reg   = 1'b0;
    is_branch    = 1'b0;
    branch_taken = 1'b0;
    case (op)
      OP_SET: begin result = imm;               writes_reg = 1'b1; end
      OP_GE:  begin result = WIDTH'(a >= b);    writes_reg = 1'b1; end
      OP_GT:  begin result = WIDTH'(a > b);     writes_reg = 1'b1; end
      OP_LE:  begin result = WIDTH'(a <= b);    writes_reg = 1'b1; end
      OP_LT:  begin result = WIDTH'(a < b);     writes_reg = 1'b1; end
      OP_NE:  begin result = WIDTH'(a != b);    writes_reg = 1'b1; end
      OP_EQ:  begin result = WIDTH'(a == b);    writes_reg = 1'b1; end
      OP_ADD: begin result = a + b;             writes_reg = 1'b1; end
      OP_JMP: begin is_branch = 1'b1; branch_taken = 1'b1;         end
      OP_JZ:  begin is_branch = 1'b1; branch_taken = (a == '0);    end
      default: ;
    endcase
  end

endmodule

// File: rtl/process_engine.sv
// rtl/process_engine.sv - single-process instruction engine: register file, pc, halt FSM
module process_engine
  import process_engine_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NREGS   = 16,
  parameter int NINSTR  = 32,
  parameter int PROC_ID = 0,
  localparam int RA      = $clog2(NREGS),
  localparam int PCW     = $clog2(NINSTR),
  localparam int INSTR_W = instr_w(WIDTH, NREGS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  output logic [PCW-1:0]     instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  output logic               stop,
  output logic [7:0]         return_code,
  output logic               retire_valid,
  output logic [PCW-1:0]     retire_pc,
  output logic [7:0]         retire_id,
  input  logic [RA-1:0]      dbg_addr,
  output logic [WIDTH-1:0]   dbg_data
);

  typedef enum logic {ST_RUN, ST_STOPPED} state_e;

  localparam logic [PCW-1:0] LAST_PC = PCW'(NINSTR - 1);

  state_e           state_q, state_d;
  logic [PCW-1:0]   pc_q, pc_d;
  logic [7:0]       rc_q, rc_d;
  logic             retire_valid_q, retire_valid_d;
  logic [PCW-1:0]   retire_pc_q, retire_pc_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  logic [3:0]       op;
  logic [RA-1:0]    dst, src_a, src_b;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] alu_result;
  logic             writes_reg, is_branch, branch_taken;

  assign op    = instr_data[INSTR_W-1 -: 4];
  assign dst   = instr_data[WIDTH+3*RA-1 -: RA];
  assign src_a = instr_data[WIDTH+2*RA-1 -: RA];
  assign src_b = instr_data[WIDTH+RA-1 -: RA];
  assign imm   = instr_data[WIDTH-1:0];

  process_alu #(.WIDTH(WIDTH)) u_alu (
    .op          (op),
    .a           (regs_q[src_a]),
    .b           (regs_q[src_b]),
    .imm         (imm),
    .result      (alu_result),
    .writes_reg  (writes_reg),
    .is_branch   (is_branch),
    .branch_taken(branch_taken)
  );

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    rc_d           = rc_q;
    regs_d         = regs_q;
    retire_valid_d = 1'b0;
    retire_pc_d    = retire_pc_q;
    if (state_q == ST_RUN && run) begin
      retire_valid_d = 1'b1;
      retire_pc_d    = pc_q;
      if (op == 4'(OP_HALT)) begin
        state_d = ST_STOPPED;
        rc_d    = RC_HALT;
      end else if (op > 4'(OP_HALT)) begin
        state_d = ST_STOPPED;
        rc_d    = RC_ILLEGAL;
      end else begin
        if (writes_reg) begin
          regs_d[dst] = alu_result;
        end
        // A not-taken branch at the last slot falls off the end just like any other op.
        if (is_branch && branch_taken) begin
          pc_d = imm[PCW-1:0];
        end else if (pc_q == LAST_PC) begin
          state_d = ST_STOPPED;
          rc_d    = RC_END;
        end else begin
          pc_d = pc_q + PCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_RUN;
      pc_q           <= '0;
      rc_q           <= RC_HALT;
      retire_valid_q <= 1'b0;
      retire_pc_q    <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      rc_q           <= rc_d;
      retire_valid_q <= retire_valid_d;
      retire_pc_q    <= retire_pc_d;
      regs_q         <= regs_d;
    end
  end

  assign instr_addr   = pc_q;
  assign stop         = (state_q == ST_STOPPED);
  assign return_code  = rc_q;
  assign retire_valid = retire_valid_q;
  assign retire_pc    = retire_pc_q;
  assign retire_id    = 8'(PROC_ID);
  assign dbg_data     = regs_q[dbg_addr];

endmodule

// File: tb/tb_process_engine.sv
// tb/tb_process_engine.sv - directed bench: default, 4-deep and 4-bit engine instances
module tb_process_engine;
  import process_engine_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;

  // default instance
  logic        run0 = 1'b0;
  logic [4:0]  addr0;
  logic [23:0] rom0 [32];
  logic [23:0] data0;
  logic        stop0, rv0;
  logic [7:0]  rc0, rid0, dbgd0;
  logic [4:0]  rpc0;
  logic [3:0]  dbga0 = '0;
  assign data0 = rom0[addr0];

  process_engine u_dut0 (
    .clock(clock), .reset(reset), .run(run0), .instr_addr(addr0), .instr_data(data0),
    .stop(stop0), .return_code(rc0), .retire_valid(rv0), .retire_pc(rpc0),
    .retire_id(rid0), .dbg_addr(dbga0), .dbg_data(dbgd0)
  );

  // NINSTR=4 instance
  logic        run1 = 1'b0;
  logic [1:0]  addr1;
  logic [23:0] rom1 [4];
  logic [23:0] data1;
  logic        stop1, rv1;
  logic [7:0]  rc1, rid1, dbgd1;
  logic [1:0]  rpc1;
  logic [3:0]  dbga1 = '0;
  assign data1 = rom1[addr1];

  process_engine #(.NINSTR(4), .PROC_ID(3)) u_dut1 (
    .clock(clock), .reset(reset), .run(run1), .instr_addr(addr1), .instr_data(data1),
    .stop(stop1), .return_code(rc1), .retire_valid(rv1), .retire_pc(rpc1),
    .retire_id(rid1), .dbg_addr(dbga1), .dbg_data(dbgd1)
  );

  // WIDTH=4 instance
  logic        run2 = 1'b0;
  logic [4:0]  addr2;
  logic [19:0] rom2 [32];
  logic [19:0] data2;
  logic        stop2, rv2;
  logic [7:0]  rc2, rid2;
  logic [3:0]  dbgd2;
  logic [4:0]  rpc2;
  logic [3:0]  dbga2 = '0;
  assign data2 = rom2[addr2];

  process_engine #(.WIDTH(4)) u_dut2 (
    .clock(clock), .reset(reset), .run(run2), .instr_addr(addr2), .instr_data(data2),
    .stop(stop2), .return_code(rc2), .retire_valid(rv2), .retire_pc(rpc2),
    .retire_id(rid2), .dbg_addr(dbga2), .dbg_data(dbgd2)
  );

  int cnt0 = 0;
  int cnt1 = 0;
  int pcs0[$];
  always @(negedge clock) begin
    if (rv0 === 1'b1) begin
      cnt0 = cnt0 + 1;
      pcs0.push_back(int'(rpc0));
    end
    if (rv1 === 1'b1) cnt1 = cnt1 + 1;
  end

  function automatic logic [23:0] enc(input logic [3:0] op, input logic [3:0] d,
                                      input logic [3:0] a, input logic [3:0] b,
                                      input logic [7:0] imm);
    return {op, d, a, b, imm};
  endfunction

  function automatic logic [19:0] enc4(input logic [3:0] op, input logic [3:0] d,
                                       input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] imm);
    return {op, d, a, b, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    run0 = 1'b0; run1 = 1'b0; run2 = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    cnt0 = 0; cnt1 = 0;
    pcs0.delete();
  endtask

  task automatic rd0(input int i, output logic [7:0] v);
    dbga0 = 4'(i);
    #1;
    v = dbgd0;
  endtask

  task automatic run_until_stop0(input int budget);
    int n = 0;
    run0 = 1'b1;
    while (stop0 !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    step();
    step();
    step();
  endtask

  task automatic load_compare();
    for (int i = 0; i < 32; i++) rom0[i] = enc(4'(OP_HALT), 0, 0, 0, 0);
    rom0[0]  = enc(4'(OP_SET), 0, 0, 0, 8'd0);
    rom0[1]  = enc(4'(OP_SET), 1, 0, 0, 8'd1);
    rom0[2]  = enc(4'(OP_GE), 4,  0, 1, 0);
    rom0[3]  = enc(4'(OP_GT), 5,  0, 1, 0);
    rom0[4]  = enc(4'(OP_LE), 6,  1, 0, 0);
    rom0[5]  = enc(4'(OP_LT), 7,  1, 0, 0);
    rom0[6]  = enc(4'(OP_NE), 8,  0, 0, 0);
    rom0[7]  = enc(4'(OP_EQ), 9,  0, 1, 0);
    rom0[8]  = enc(4'(OP_GE), 10, 1, 0, 0);
    rom0[9]  = enc(4'(OP_GT), 11, 1, 0, 0);
    rom0[10] = enc(4'(OP_LE), 12, 0, 1, 0);
    rom0[11] = enc(4'(OP_LT), 13, 0, 1, 0);
    rom0[12] = enc(4'(OP_NE), 14, 0, 1, 0);
    rom0[13] = enc(4'(OP_EQ), 15, 1, 1, 0);
    rom0[14] = enc(4'(OP_HALT), 0, 0, 0, 0);
  endtask

  task automatic check_compare_regs(input string pfx);
    logic [7:0] v;
    for (int i = 4; i < 16; i++) begin
      rd0(i, v);
      check($sformatf("%s_r%0d", pfx, i), 32'(v), (i >= 10) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    logic [7:0] v;
    int exp_pcs[11] = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 5};
    int n;
    logic [4:0] pc_hold;

    for (int i = 0; i < 4; i++) rom1[i] = enc(4'(OP_HALT), 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) rom2[i] = enc4(4'(OP_HALT), 0, 0, 0, 0);

    // compare program
    load_compare();
    do_reset();
    check("rst_pc", 32'(addr0), 32'd0);
    check("rst_stop", 32'(stop0), 32'd0);
    check("rst_rc", 32'(rc0), 32'd0);
    check("rst_rv", 32'(rv0), 32'd0);
    check("rst_rpc", 32'(rpc0), 32'd0);
    check("rst_id1", 32'(rid1), 32'd3);
    rd0(5, v);
    check("rst_r5", 32'(v), 32'd0);
    run_until_stop0(100);
    check("cmp_stop", 32'(stop0), 32'd1);
    check("cmp_rc", 32'(rc0), 32'(RC_HALT));
    check("cmp_retires", 32'(cnt0), 32'd15);
    check("cmp_halt_pc", 32'(addr0), 32'd14);
    check_compare_regs("cmp");

    // countdown loop
    for (int i = 0; i < 32; i++) rom0[i] = enc(4'(OP_HALT), 0, 0, 0, 0);
    rom0[0] = enc(4'(OP_SET), 0, 0, 0, 8'd3);
    rom0[1] = enc(4'(OP_SET), 1, 0, 0, 8'd255);
    rom0[2] = enc(4'(OP_ADD), 0, 0, 1, 0);
    rom0[3] = enc(4'(OP_JZ), 0, 0, 0, 8'd5);
    rom0[4] = enc(4'(OP_JMP), 0, 0, 0, 8'd2);
    rom0[5] = enc(4'(OP_HALT), 0, 0, 0, 0);
    do_reset();
    run_until_stop0(100);
    rd0(0, v);
    check("loop_r0", 32'(v), 32'd0);
    check("loop_stop", 32'(stop0), 32'd1);
    check("loop_rc", 32'(rc0), 32'(RC_HALT));
    check("loop_len", 32'(pcs0.size()), 32'd11);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("loop_pc%0d", i), (i < pcs0.size()) ? 32'(pcs0[i]) : 32'hffff_ffff,
            32'(exp_pcs[i]));
    end

    // run off end on the 4-deep engine
    rom1[0] = enc(4'(OP_SET), 0, 0, 0, 8'd7);
    rom1[1] = enc(4'(OP_SET), 1, 0, 0, 8'd8);
    rom1[2] = enc(4'(OP_SET), 2, 0, 0, 8'd9);
    rom1[3] = enc(4'(OP_SET), 3, 0, 0, 8'd10);
    do_reset();
    run1 = 1'b1;
    n = 0;
    while (stop1 !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    step();
    step();
    step();
    dbga1 = 4'd3;
    #1;
    check("end_r3", 32'(dbgd1), 32'd10);
    check("end_stop", 32'(stop1), 32'd1);
    check("end_rc", 32'(rc1), 32'(RC_END));
    check("end_pc", 32'(addr1), 32'd3);
    check("end_retires", 32'(cnt1), 32'd4);
    check("end_rv_idle", 32'(rv1), 32'd0);
    run1 = 1'b0;

    // illegal opcode at pc=1
    for (int i = 0; i < 32; i++) rom0[i] = enc(4'(OP_HALT), 0, 0, 0, 0);
    rom0[0] = enc(4'(OP_SET), 0, 0, 0, 8'd5);
    rom0[1] = enc(4'd13, 1, 0, 0, 8'd99);
    rom0[2] = enc(4'(OP_SET), 2, 0, 0, 8'd42);
    do_reset();
    run_until_stop0(20);
    check("ill_stop", 32'(stop0), 32'd1);
    check("ill_rc", 32'(rc0), 32'(RC_ILLEGAL));
    check("ill_retires", 32'(cnt0), 32'd2);
    check("ill_pc", 32'(addr0), 32'd1);
    rd0(0, v);
    check("ill_r0", 32'(v), 32'd5);
    rd0(1, v);
    check("ill_r1", 32'(v), 32'd0);
    rd0(2, v);
    check("ill_r2", 32'(v), 32'd0);

    // run gating, then reset mid-program
    load_compare();
    do_reset();
    run0 = 1'b1;
    step();
    pc_hold = addr0;
    check("gate_pc1", 32'(pc_hold), 32'd1);
    run0 = 1'b0;
    step();
    check("gate_hold_a", 32'(addr0), 32'(pc_hold));
    check("gate_rv_a", 32'(rv0), 32'd0);
    step();
    check("gate_hold_b", 32'(addr0), 32'(pc_hold));
    check("gate_rv_b", 32'(rv0), 32'd0);
    run0 = 1'b1;
    n = 0;
    while (addr0 !== 5'd7 && n < 30) begin
      step();
      n++;
    end
    check("gate_at7", 32'(addr0), 32'd7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run0 = 1'b0;
    check("mid_rst_pc", 32'(addr0), 32'd0);
    check("mid_rst_stop", 32'(stop0), 32'd0);
    check("mid_rst_rv", 32'(rv0), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd0(i, v);
      check($sformatf("mid_rst_r%0d", i), 32'(v), 32'd0);
    end
    cnt0 = 0;
    pcs0.delete();
    run_until_stop0(100);
    check("rerun_stop", 32'(stop0), 32'd1);
    check("rerun_rc", 32'(rc0), 32'(RC_HALT));
    check("rerun_retires", 32'(cnt0), 32'd15);
    check_compare_regs("rerun");

    // 4-bit overflow
    rom2[0] = enc4(4'(OP_SET), 0, 0, 0, 4'd15);
    rom2[1] = enc4(4'(OP_SET), 1, 0, 0, 4'd1);
    rom2[2] = enc4(4'(OP_ADD), 2, 0, 1, 0);
    rom2[3] = enc4(4'(OP_GT), 3, 0, 1, 0);
    rom2[4] = enc4(4'(OP_HALT), 0, 0, 0, 0);
    do_reset();
    run2 = 1'b1;
    n = 0;
    while (stop2 !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    run2 = 1'b0;
    check("w4_stop", 32'(stop2), 32'd1);
    dbga2 = 4'd2;
    #1;
    check("w4_r2", 32'(dbgd2), 32'd0);
    dbga2 = 4'd3;
    #1;
    check("w4_r3", 32'(dbgd2), 32'd1);
    dbga2 = 4'd0;
    #1;
    check("w4_r0", 32'(dbgd2), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
